// File: rtl/bsg_fifo_rolly_retry_ctrl.sv
// Retry controller for a rolly FIFO: commits or drops written packets, and on the
// read side replays packets until they are acked, retries run out, or abort_i flushes.
module bsg_fifo_rolly_retry_ctrl
  #(parameter int pkt_beats_width_p = 8
   ,parameter int max_retry_p       = 3
   ,parameter int timeout_p         = 64
   )
  (input  logic clk_i
  ,input  logic reset_i

  ,input  logic enq_v_i
  ,input  logic enq_last_i
  ,input  logic enq_err_i
  ,output logic commit_not_drop_v_o
  ,output logic commit_not_drop_o

  ,input  logic rd_v_i
  ,input  logic rd_last_i
  ,output logic out_v_o
  ,input  logic out_yumi_i
  ,output logic fifo_yumi_o

  ,output logic deq_v_o
  ,output logic rollback_v_o
  ,output logic clr_v_o

  ,input  logic resp_v_i
  ,input  logic resp_ack_i
  ,input  logic abort_i

  ,output logic pkt_done_o
  ,output logic give_up_o
  ,output logic [$clog2(max_retry_p+1)-1:0] retry_cnt_o
  );

  localparam int retry_width_lp = $clog2(max_retry_p+1);
  localparam int timer_width_lp = $clog2(timeout_p);

  localparam logic [pkt_beats_width_p-1:0] one_beat_lp     = pkt_beats_width_p'(1);
  localparam logic [retry_width_lp-1:0]    one_retry_lp    = retry_width_lp'(1);
  localparam logic [retry_width_lp-1:0]    max_retry_lp    = retry_width_lp'(max_retry_p);
  localparam logic [timer_width_lp-1:0]    one_tick_lp     = timer_width_lp'(1);
  localparam logic [timer_width_lp-1:0]    timer_last_lp   = timer_width_lp'(timeout_p-1);

  typedef enum logic [1:0] {SEND, WAIT_RESP, REWIND, RELEASE} state_e;

  state_e                        state_r;
  logic [pkt_beats_width_p-1:0]  beat_cnt_r;
  logic [retry_width_lp-1:0]     retry_cnt_r;
  logic [timer_width_lp-1:0]     timer_r;
  logic                          err_seen_r;

  logic live, run;
  logic resp_ok, resp_fail, retries_left;

  assign live = ~reset_i;
  assign run  = live & ~abort_i;

  assign commit_not_drop_v_o = run & enq_v_i & enq_last_i;
  assign commit_not_drop_o   = live & ~(err_seen_r | enq_err_i);

  assign out_v_o      = run & (state_r == SEND) & rd_v_i;
  assign fifo_yumi_o  = out_v_o & out_yumi_i;
  assign deq_v_o      = run & (state_r == RELEASE);
  assign rollback_v_o = run & (state_r == REWIND);
  assign clr_v_o      = live & abort_i;

  assign resp_ok      = (state_r == WAIT_RESP) & resp_v_i & resp_ack_i;
  assign resp_fail    = (state_r == WAIT_RESP)
                        & (resp_v_i ? ~resp_ack_i : (timer_r == timer_last_lp));
  assign retries_left = (retry_cnt_r < max_retry_lp);

  assign give_up_o   = run & resp_fail & ~retries_left;
  assign pkt_done_o  = deq_v_o & (beat_cnt_r <= one_beat_lp);
  assign retry_cnt_o = live ? retry_cnt_r : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i | abort_i) begin
      state_r     <= SEND;
      beat_cnt_r  <= '0;
      retry_cnt_r <= '0;
      timer_r     <= '0;
      err_seen_r  <= '0;
    end else begin
      if (enq_v_i & enq_last_i)
        err_seen_r <= 1'b0;
      else if (enq_v_i & enq_err_i)
        err_seen_r <= 1'b1;

      unique case (state_r)
        SEND: begin
          // Replayed beats after a rewind are already counted; only the first pass counts.
          if (fifo_yumi_o && (retry_cnt_r == '0)) begin
            assert (beat_cnt_r != '1);
            beat_cnt_r <= beat_cnt_r + one_beat_lp;
          end
          if (fifo_yumi_o && rd_last_i) begin
            state_r <= WAIT_RESP;
            timer_r <= '0;
          end
        end
        WAIT_RESP: begin
          timer_r <= timer_r + one_tick_lp;
          if (resp_ok)
            state_r <= RELEASE;
          else if (resp_fail) begin
            if (retries_left) begin
              retry_cnt_r <= retry_cnt_r + one_retry_lp;
              state_r     <= REWIND;
            end else
              state_r <= RELEASE;
          end
        end
        REWIND: state_r <= SEND;
        RELEASE: begin
          beat_cnt_r <= beat_cnt_r - one_beat_lp;
          if (beat_cnt_r <= one_beat_lp) begin
            beat_cnt_r  <= '0;
            retry_cnt_r <= '0;
            state_r     <= SEND;
          end
        end
        default: state_r <= SEND;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_fifo_rolly_retry_ctrl.sv
// Cycle-by-cycle bench for bsg_fifo_rolly_retry_ctrl: expected output vectors are queued
// as each cycle's stimulus is driven and compared once the DUT settles.
module tb_bsg_fifo_rolly_retry_ctrl;

  logic clk_i = 1'b0;
  logic reset_i;
  logic enq_v_i, enq_last_i, enq_err_i;
  logic commit_not_drop_v_o, commit_not_drop_o;
  logic rd_v_i, rd_last_i, out_v_o, out_yumi_i, fifo_yumi_o;
  logic deq_v_o, rollback_v_o, clr_v_o;
  logic resp_v_i, resp_ack_i, abort_i;
  logic pkt_done_o, give_up_o;
  logic [1:0] retry_cnt_o;

  bsg_fifo_rolly_retry_ctrl
    #(.pkt_beats_width_p(8)
     ,.max_retry_p(3)
     ,.timeout_p(8)
     )
  dut
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.enq_v_i(enq_v_i)
    ,.enq_last_i(enq_last_i)
    ,.enq_err_i(enq_err_i)
    ,.commit_not_drop_v_o(commit_not_drop_v_o)
    ,.commit_not_drop_o(commit_not_drop_o)
    ,.rd_v_i(rd_v_i)
    ,.rd_last_i(rd_last_i)
    ,.out_v_o(out_v_o)
    ,.out_yumi_i(out_yumi_i)
    ,.fifo_yumi_o(fifo_yumi_o)
    ,.deq_v_o(deq_v_o)
    ,.rollback_v_o(rollback_v_o)
    ,.clr_v_o(clr_v_o)
    ,.resp_v_i(resp_v_i)
    ,.resp_ack_i(resp_ack_i)
    ,.abort_i(abort_i)
    ,.pkt_done_o(pkt_done_o)
    ,.give_up_o(give_up_o)
    ,.retry_cnt_o(retry_cnt_o)
    );

  always #5 clk_i = ~clk_i;

  localparam logic [8:0] F_CV   = 9'b1_0000_0000;
  localparam logic [8:0] F_C    = 9'b0_1000_0000;
  localparam logic [8:0] F_OV   = 9'b0_0100_0000;
  localparam logic [8:0] F_Y    = 9'b0_0010_0000;
  localparam logic [8:0] F_DQ   = 9'b0_0001_0000;
  localparam logic [8:0] F_RB   = 9'b0_0000_1000;
  localparam logic [8:0] F_CLR  = 9'b0_0000_0100;
  localparam logic [8:0] F_DONE = 9'b0_0000_0010;
  localparam logic [8:0] F_GU   = 9'b0_0000_0001;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [10:0] exp_q[$];

  function automatic logic [10:0] ev(input logic [8:0] f, input logic [1:0] rc);
    return {f, rc};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got[10:0], exp[10:0]);
    end
  endtask

  task automatic idle_inputs();
    enq_v_i = 0; enq_last_i = 0; enq_err_i = 0;
    rd_v_i = 0; rd_last_i = 0; out_yumi_i = 0;
    resp_v_i = 0; resp_ack_i = 0; abort_i = 0;
  endtask

  // Inputs are set by the caller just after a falling edge; outputs sampled 1ns later.
  task automatic cyc(input string tag, input logic [10:0] exp);
    logic [10:0] got;
    exp_q.push_back(exp);
    #1;
    got = {commit_not_drop_v_o, commit_not_drop_o, out_v_o, fifo_yumi_o, deq_v_o,
           rollback_v_o, clr_v_o, pkt_done_o, give_up_o, retry_cnt_o};
    check_eq(tag, 32'(got), 32'(exp_q.pop_front()));
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic send_pkt(input int n, input logic [1:0] rc, input string tag);
    for (int i = 0; i < n; i++) begin
      rd_v_i = 1; out_yumi_i = 1; rd_last_i = (i == n-1);
      cyc(tag, ev(F_C | F_OV | F_Y, rc));
    end
  endtask

  task automatic silent(input int n, input logic [1:0] rc, input string tag);
    for (int i = 0; i < n; i++) cyc(tag, ev(F_C, rc));
  endtask

  task automatic resp_cyc(input logic ack, input logic [1:0] rc, input string tag);
    resp_v_i = 1; resp_ack_i = ack;
    cyc(tag, ev(F_C, rc));
  endtask

  task automatic release_pkt(input int n, input logic [1:0] rc, input string tag);
    for (int i = 0; i < n; i++)
      cyc(tag, ev(F_C | F_DQ | ((i == n-1) ? F_DONE : 9'b0), rc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset_i = 1;
    @(negedge clk_i);

    // reset dominates every input
    for (int i = 0; i < 2; i++) begin
      enq_v_i = 1; enq_last_i = 1; rd_v_i = 1; out_yumi_i = 1; abort_i = 1; resp_v_i = 1;
      cyc("reset", ev(9'b0, 2'd0));
    end
    reset_i = 0;
    cyc("post_reset", ev(F_C, 2'd0));

    // clean 4-beat write packet
    for (int i = 0; i < 3; i++) begin enq_v_i = 1; cyc("wr_clean", ev(F_C, 2'd0)); end
    enq_v_i = 1; enq_last_i = 1; cyc("wr_clean_last", ev(F_CV | F_C, 2'd0));

    // 3-beat packet corrupt on beat 2, idle gap, then a clean packet
    enq_v_i = 1; cyc("wr_err_b1", ev(F_C, 2'd0));
    enq_v_i = 1; enq_err_i = 1; cyc("wr_err_b2", ev(9'b0, 2'd0));
    cyc("wr_err_gap", ev(9'b0, 2'd0));
    enq_v_i = 1; enq_last_i = 1; cyc("wr_err_last", ev(F_CV, 2'd0));
    enq_v_i = 1; cyc("wr_next_b1", ev(F_C, 2'd0));
    enq_v_i = 1; enq_last_i = 1; cyc("wr_next_last", ev(F_CV | F_C, 2'd0));
    enq_v_i = 1; enq_last_i = 1; enq_err_i = 1; cyc("wr_single_err", ev(F_CV, 2'd0));
    cyc("wr_single_after", ev(F_C, 2'd0));

    // 4-beat read with a stall and a stray nack in SEND, ack after 2 waits
    rd_v_i = 1; out_yumi_i = 1; cyc("r1_send", ev(F_C | F_OV | F_Y, 2'd0));
    rd_v_i = 1; resp_v_i = 1; cyc("r1_stall", ev(F_C | F_OV, 2'd0));
    send_pkt(3, 2'd0, "r1_send");
    silent(2, 2'd0, "r1_wait");
    resp_cyc(1'b1, 2'd0, "r1_ack");
    release_pkt(4, 2'd0, "r1_release");
    cyc("r1_idle", ev(F_C, 2'd0));

    // nack -> one rewind, replay, ack -> 4 deqs
    send_pkt(4, 2'd0, "r2_send");
    resp_cyc(1'b0, 2'd0, "r2_nack");
    cyc("r2_rewind", ev(F_C | F_RB, 2'd1));
    send_pkt(4, 2'd1, "r2_resend");
    resp_cyc(1'b1, 2'd1, "r2_ack");
    release_pkt(4, 2'd1, "r2_release");
    cyc("r2_idle", ev(F_C, 2'd0));

    // silence -> 3 rewinds at 8-cycle timeouts, then give up and release
    for (int r = 0; r < 4; r++) begin
      send_pkt(4, 2'(r), "r3_send");
      silent(7, 2'(r), "r3_wait");
      if (r < 3) begin
        cyc("r3_timeout", ev(F_C, 2'(r)));
        cyc("r3_rewind", ev(F_C | F_RB, 2'(r+1)));
      end else
        cyc("r3_give_up", ev(F_C | F_GU, 2'd3));
    end
    release_pkt(4, 2'd3, "r3_release");
    cyc("r3_idle", ev(F_C, 2'd0));

    // ack arriving on the final timer cycle wins over the timeout
    send_pkt(1, 2'd0, "r4_send");
    silent(7, 2'd0, "r4_wait");
    resp_cyc(1'b1, 2'd0, "r4_late_ack");
    release_pkt(1, 2'd0, "r4_release");
    cyc("r4_idle", ev(F_C, 2'd0));

    // abort after 2 of 4 deqs; next packet of 1 beat must release exactly once
    send_pkt(4, 2'd0, "r5_send");
    resp_cyc(1'b1, 2'd0, "r5_ack");
    cyc("r5_deq1", ev(F_C | F_DQ, 2'd0));
    cyc("r5_deq2", ev(F_C | F_DQ, 2'd0));
    abort_i = 1; enq_v_i = 1; enq_last_i = 1;
    cyc("r5_abort", ev(F_C | F_CLR, 2'd0));
    send_pkt(1, 2'd0, "r5_send_after");
    resp_cyc(1'b1, 2'd0, "r5_ack2");
    release_pkt(1, 2'd0, "r5_release");
    cyc("r5_idle", ev(F_C, 2'd0));

    // abort during REWIND also clears retry count and err_seen
    send_pkt(2, 2'd0, "r6_send");
    resp_v_i = 1; resp_ack_i = 0; enq_v_i = 1; enq_err_i = 1;
    cyc("r6_nack_err", ev(9'b0, 2'd0));
    abort_i = 1; cyc("r6_abort_rewind", ev(F_CLR, 2'd1));
    cyc("r6_idle", ev(F_C, 2'd0));
    send_pkt(1, 2'd0, "r6_send_after");
    resp_cyc(1'b1, 2'd0, "r6_ack");
    release_pkt(1, 2'd0, "r6_release");
    cyc("r6_idle2", ev(F_C, 2'd0));

    // reset mid-RELEASE
    send_pkt(3, 2'd0, "r7_send");
    resp_cyc(1'b1, 2'd0, "r7_ack");
    cyc("r7_deq1", ev(F_C | F_DQ, 2'd0));
    reset_i = 1; rd_v_i = 1; out_yumi_i = 1;
    cyc("r7_reset", ev(9'b0, 2'd0));
    reset_i = 0;
    cyc("r7_idle", ev(F_C, 2'd0));
    send_pkt(1, 2'd0, "r7_send_after");
    resp_cyc(1'b1, 2'd0, "r7_ack2");
    release_pkt(1, 2'd0, "r7_release");
    cyc("r7_idle2", ev(F_C, 2'd0));

    // reset mid-REWIND
    send_pkt(1, 2'd0, "r8_send");
    resp_cyc(1'b0, 2'd0, "r8_nack");
    reset_i = 1; cyc("r8_reset", ev(9'b0, 2'd0));
    reset_i = 0;
    cyc("r8_idle", ev(F_C, 2'd0));
    send_pkt(1, 2'd0, "r8_send_after");
    resp_cyc(1'b1, 2'd0, "r8_ack");
    release_pkt(1, 2'd0, "r8_release");
    cyc("r8_idle2", ev(F_C, 2'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_rolly_retry_ctrl.md
BSG_FIFO_ROLLY_RETRY_CTRL -- requirements
Module: bsg_fifo_rolly_retry_ctrl

Interface
REQ-001 SHALL have parameter pkt_beats_width_p, default 8: width of the per-packet beat counter.
REQ-002 SHALL have parameter max_retry_p, default 3: number of rewinds allowed per packet before the controller gives up.
REQ-003 SHALL have parameter timeout_p, default 64: number of cycles WAIT_RESP waits for a response; SHALL be at least 2.
REQ-004 SHALL have one clock, clk_i (input, 1): all state updates on its rising edge.
REQ-005 SHALL have reset_i (input, 1): reset is synchronous and active-high.
REQ-006 enq_v_i (input, 1): a write beat was accepted by the FIFO this cycle.
REQ-007 enq_last_i (input, 1): the accepted beat is the last beat of its packet.
REQ-008 enq_err_i (input, 1): the accepted beat is corrupt.
REQ-009 commit_not_drop_v_o (output, 1), commit_not_drop_o (output, 1): commit/drop command to the FIFO.
REQ-010 rd_v_i (input, 1): FIFO read valid.
REQ-011 rd_last_i (input, 1): the FIFO head beat is the last beat of its packet.
REQ-012 out_v_o (output, 1): gated valid to the consumer.
REQ-013 out_yumi_i (input, 1): the consumer takes the head beat.
REQ-014 fifo_yumi_o (output, 1): read strobe to the FIFO.
REQ-015 deq_v_o (output, 1), rollback_v_o (output, 1), clr_v_o (output, 1): checkpoint controls to the FIFO.
REQ-016 resp_v_i (input, 1), resp_ack_i (input, 1): receiver response; ack=1, nack=0.
REQ-017 abort_i (input, 1): flush all in-flight and uncommitted data.
REQ-018 pkt_done_o (output, 1), give_up_o (output, 1): one-cycle status pulses.
REQ-019 retry_cnt_o (output, clog2(max_retry_p+1)): retry count of the current packet.

Function
REQ-020 Write side SHALL be combinational:
- commit_not_drop_v_o = enq_v_i & enq_last_i
- commit_not_drop_o = ~(err_seen_r | enq_err_i)
REQ-021 err_seen_r SHALL set on enq_v_i & enq_err_i & ~enq_last_i, and SHALL clear on enq_v_i & enq_last_i and on abort_i.
REQ-022 The read FSM SHALL have states SEND, WAIT_RESP, REWIND and RELEASE.
REQ-023 In SEND:
- out_v_o = rd_v_i; fifo_yumi_o = rd_v_i & out_yumi_i
- each fifo_yumi_o increments beat_cnt
- fifo_yumi_o with rd_last_i -> WAIT_RESP, timer cleared to 0
REQ-024 In every state other than SEND, out_v_o and fifo_yumi_o SHALL be 0.
REQ-025 In WAIT_RESP the timer SHALL increment by 1 each cycle.
REQ-026 In WAIT_RESP, resp_v_i & resp_ack_i SHALL move the FSM to RELEASE.
REQ-027 In WAIT_RESP, a fail event (resp_v_i & ~resp_ack_i, or timer == timeout_p-1 with no resp_v_i) SHALL behave as follows:
- retry_cnt < max_retry_p: retry_cnt increments, FSM moves to REWIND
- otherwise: give_up_o pulses and FSM moves to RELEASE
REQ-028 REWIND SHALL last exactly 1 cycle with rollback_v_o = 1, keep beat_cnt unchanged, then return to SEND.
REQ-029 In RELEASE, deq_v_o SHALL be 1 every cycle and beat_cnt SHALL decrement by 1 per cycle.
REQ-030 In RELEASE, the cycle with beat_cnt == 1 SHALL also pulse pkt_done_o, clear retry_cnt, and return the FSM to SEND.
REQ-031 deq_v_o and rollback_v_o SHALL never both be asserted in the same cycle.
REQ-032 resp_v_i SHALL be ignored outside WAIT_RESP.
REQ-033 abort_i SHALL have priority over every other event:
- clr_v_o = 1 in the same cycle
- next cycle: SEND, beat_cnt = 0, retry_cnt = 0, timer = 0, err_seen_r = 0
- deq_v_o, rollback_v_o and commit_not_drop_v_o forced to 0 in the abort cycle
REQ-034 A packet longer than 2^pkt_beats_width_p - 1 beats is illegal and SHALL trigger a simulation assertion.
REQ-035 Write-side and read-side logic SHALL operate concurrently with no interaction other than abort_i.

Reset
REQ-036 While reset_i is asserted:
- FSM = SEND; beat_cnt, retry_cnt, timer and err_seen_r = 0
- every output = 0
REQ-037 Reset asserted in any state, including mid-RELEASE or mid-REWIND, SHALL take effect on the next edge with no residual pulses.

Verification
REQ-038 The bench SHALL cover: 4-beat packet with no error, last beat accepted -> commit_not_drop_v_o = 1 and commit_not_drop_o = 1 in that cycle.
REQ-039 The bench SHALL cover: 3-beat packet with enq_err_i on beat 2 -> commit_not_drop_o = 0 on beat 3, then the next clean packet commits.
REQ-040 The bench SHALL cover: 4-beat packet read, ack 2 cycles later -> deq_v_o high 4 consecutive cycles, then pkt_done_o, then retry_cnt_o = 0.
REQ-041 The bench SHALL cover: nack after read -> 1 cycle of rollback_v_o, retry_cnt_o = 1, the same 4 beats re-presented, then ack -> 4 deqs.
REQ-042 The bench SHALL cover, with max_retry_p = 3 and timeout_p = 8: no response, ever -> 3 rewinds spaced by 8-cycle waits, then give_up_o and 4 deqs.
REQ-043 The bench SHALL cover: abort_i mid-RELEASE after 2 deqs -> clr_v_o = 1 that cycle, no deq_v_o in that cycle, FSM in SEND next cycle, all counters 0.
